// File: rtl/result_display_driver_pkg.sv
// Shared types and constants for the result display driver: converter states,
// active-low 7-segment glyphs and the digit decode helper.
package result_display_driver_pkg;

  localparam int RESULT_WIDTH = 8;
  localparam int BCD_WIDTH    = 12;
  localparam int NUM_DIGITS   = 3;

  typedef enum logic {
    IDLE,
    CONVERT
  } conv_state_t;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is driven low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/result_display_driver_bin_to_bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per clock, RESULT_WIDTH steps.
// done and bcd are combinational on the final step so the caller can chain
// a new conversion on the same edge without a dead cycle.
module bin_to_bcd_seq
  import result_display_driver_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [RESULT_WIDTH-1:0] value,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_WIDTH-1:0]    bcd
);

  localparam logic [2:0] LAST_ITER = 3'(RESULT_WIDTH - 1);

  conv_state_t             state_q, state_d;
  logic [RESULT_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_WIDTH-1:0]    acc_q, acc_d;
  logic [2:0]              iter_q, iter_d;
  logic [BCD_WIDTH-1:0]    acc_adj;
  logic [BCD_WIDTH-1:0]    acc_step;

  always_comb begin
    acc_adj = acc_q;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (acc_q[4*n +: 4] >= 4'd5) acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
    end
    acc_step = {acc_adj[BCD_WIDTH-2:0], bin_q[RESULT_WIDTH-1]};
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = value;
          acc_d   = '0;
          iter_d  = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bin_d  = {bin_q[RESULT_WIDTH-2:0], 1'b0};
        acc_d  = acc_step;
        iter_d = iter_q + 3'd1;
        if (iter_q == LAST_ITER) begin
          done = 1'b1;
          if (start) begin
            bin_d  = value;
            acc_d  = '0;
            iter_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
    end
  end

  assign busy = (state_q == CONVERT);
  assign bcd  = acc_step;

endmodule

// File: rtl/result_display_driver.sv
// Captures O-register results, converts them to BCD and scans them onto a
// multiplexed active-low 7-segment display with optional leading-zero blanking.
module result_display_driver
  import result_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [RESULT_WIDTH-1:0] result_in,
  input  logic                    result_valid,
  output logic                    busy,
  output logic [6:0]              seg,
  output logic [3:0]              an
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic                    conv_busy;
  logic                    conv_done;
  logic [BCD_WIDTH-1:0]    conv_bcd;
  logic                    take_new;
  logic                    conv_start;
  logic [RESULT_WIDTH-1:0] conv_value;

  logic                    pending_valid;
  logic [RESULT_WIDTH-1:0] pending_value;
  logic [BCD_WIDTH-1:0]    display_bcd;

  logic [PW-1:0]           presc;
  logic [1:0]              digit_idx;
  logic [3:0]              an_d;
  logic [6:0]              seg_d;
  logic [3:0]              hundreds, tens, units;

  // A fresh strobe always beats the pending value: the newest result wins.
  assign take_new   = result_valid && (!conv_busy || conv_done);
  assign conv_start = take_new || (conv_done && pending_valid);
  assign conv_value = take_new ? result_in : pending_value;

  bin_to_bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .value (conv_value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_valid <= 1'b0;
      pending_value <= '0;
    end else if (result_valid && conv_busy && !conv_done) begin
      pending_valid <= 1'b1;
      pending_value <= result_in;
    end else if (conv_done) begin
      pending_valid <= 1'b0;
    end
  end

  // Whole-value update only when a conversion finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) display_bcd <= '0;
    else if (conv_done) display_bcd <= conv_bcd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      digit_idx <= 2'd0;
    end else if (presc == PRESC_LAST) begin
      presc     <= '0;
      digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign hundreds = display_bcd[11:8];
  assign tens     = display_bcd[7:4];
  assign units    = display_bcd[3:0];

  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    case (digit_idx)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = seg_decode(units);
      end
      2'd1: begin
        if (!(BLANK_LZ && hundreds == 4'd0 && tens == 4'd0)) begin
          an_d  = 4'b1101;
          seg_d = seg_decode(tens);
        end
      end
      2'd2: begin
        if (!(BLANK_LZ && hundreds == 4'd0)) begin
          an_d  = 4'b1011;
          seg_d = seg_decode(hundreds);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

  assign busy = conv_busy;

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver: two instances (blanking on/off)
// share stimulus; a vector table plus hand-written multi-cycle sequences.
module tb_result_display_driver;

  localparam logic [6:0] BLANK = 7'b1111111;

  typedef struct {
    logic [7:0] value;
    int         h;
    int         t;
    int         u;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [7:0] result_in;
  logic       result_valid;
  logic       busy_lz, busy_nz;
  logic [6:0] seg_lz, seg_nz;
  logic [3:0] an_lz, an_nz;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_rom [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  result_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_lz (
    .clk(clk), .reset(reset), .result_in(result_in), .result_valid(result_valid),
    .busy(busy_lz), .seg(seg_lz), .an(an_lz)
  );

  result_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nz (
    .clk(clk), .reset(reset), .result_in(result_in), .result_valid(result_valid),
    .busy(busy_nz), .seg(seg_nz), .an(an_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic int slot_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b1111: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input bit blz, input int slot,
                                         input int h, input int t, input int u);
    case (slot)
      0:       return seg_rom[u];
      1:       return (blz && h == 0 && t == 0) ? BLANK : seg_rom[t];
      default: return (blz && h == 0) ? BLANK : seg_rom[h];
    endcase
  endfunction

  function automatic bit consistent(input logic [3:0] a, input logic [6:0] s,
                                    input int h, input int t, input int u);
    int sl;
    sl = slot_of(a);
    if (sl < 3) return s == exp_seg(1'b1, sl, h, t, u);
    if (sl == 3) return s == BLANK;
    return 1'b0;
  endfunction

  // Samples one full scan (12 cycles = 3 slots x 4) on both instances.
  task automatic scan_check(input string name, input int h, input int t, input int u);
    logic [6:0] seen [2][3];
    int         blanks [2];
    int         odd [2];
    int         exp_blanks;
    logic [3:0] a;
    logic [6:0] s;
    int         sl;
    for (int d = 0; d < 2; d++) begin
      blanks[d] = 0;
      odd[d]    = 0;
      for (int k = 0; k < 3; k++) seen[d][k] = BLANK;
    end
    repeat (12) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        a  = (d == 0) ? an_lz : an_nz;
        s  = (d == 0) ? seg_lz : seg_nz;
        sl = slot_of(a);
        if (sl < 3) begin
          if (seen[d][sl] != BLANK && seen[d][sl] != s) odd[d]++;
          seen[d][sl] = s;
        end else if (sl == 3) begin
          blanks[d]++;
          if (s != BLANK) odd[d]++;
        end else begin
          odd[d]++;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      exp_blanks = 0;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("%s blz%0d slot%0d seg", name, 1 - d, k),
              seen[d][k], exp_seg(d == 0, k, h, t, u));
        if (exp_seg(d == 0, k, h, t, u) == BLANK) exp_blanks += 4;
      end
      check($sformatf("%s blz%0d blank_cycles", name, 1 - d), blanks[d], exp_blanks);
      check($sformatf("%s blz%0d bad_samples", name, 1 - d), odd[d], 0);
    end
  endtask

  task automatic strobe_first(input logic [7:0] v);
    result_in    = v;
    result_valid = 1'b1;
    @(posedge clk);
    #1 result_valid = 1'b0;
  endtask

  task automatic run_vector(input string name, input logic [7:0] v,
                            input int h, input int t, input int u);
    int cnt;
    cnt = 0;
    strobe_first(v);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy_lz) cnt++;
      else break;
    end
    check({name, " busy_cycles"}, cnt, 8);
    @(negedge clk);
    scan_check(name, h, t, u);
  endtask

  vec_t vecs [8];

  initial begin
    int busy_cnt, win_bad, ghost;

    vecs[0] = '{8'd255, 2, 5, 5};
    vecs[1] = '{8'd7,   0, 0, 7};
    vecs[2] = '{8'd0,   0, 0, 0};
    vecs[3] = '{8'd10,  0, 1, 0};
    vecs[4] = '{8'd100, 1, 0, 0};
    vecs[5] = '{8'd99,  0, 9, 9};
    vecs[6] = '{8'd128, 1, 2, 8};
    vecs[7] = '{8'd206, 2, 0, 6};

    reset        = 1'b1;
    result_in    = '0;
    result_valid = 1'b0;

    // Reset state, then the idle display of 0.
    repeat (3) @(negedge clk);
    check("rst busy", busy_lz, 0);
    check("rst an", an_lz, 4'b1111);
    check("rst seg", seg_lz, BLANK);
    check("rst an nz", an_nz, 4'b1111);
    reset = 1'b0;
    @(negedge clk);
    check("first an", an_lz, 4'b1110);
    check("first seg", seg_lz, 7'b1000000);
    scan_check("after_reset", 0, 0, 0);

    for (int v = 0; v < 8; v++)
      run_vector($sformatf("vec%0d_%0d", v, vecs[v].value),
                 vecs[v].value, vecs[v].h, vecs[v].t, vecs[v].u);

    // Pending overwrite: 100, then 42 and 9 mid-conversion; 42 must never show.
    run_vector("prep255", 8'd255, 2, 5, 5);
    busy_cnt = 0; win_bad = 0; ghost = 0;
    strobe_first(8'd100);
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (busy_lz) busy_cnt++;
      if (n >= 10 && n <= 17 && !consistent(an_lz, seg_lz, 1, 0, 0)) win_bad++;
      if ((slot_of(an_lz) == 1 && seg_lz == seg_rom[4]) ||
          (slot_of(an_lz) == 0 && seg_lz == seg_rom[2])) ghost++;
      result_valid = (n == 3 || n == 5);
      result_in    = (n == 3) ? 8'd42 : 8'd9;
    end
    result_valid = 1'b0;
    check("overwrite busy_cycles", busy_cnt, 16);
    check("overwrite shows 100", win_bad, 0);
    check("overwrite 42 seen", ghost, 0);
    scan_check("overwrite_final9", 0, 0, 9);

    // Back-to-back: 0, then 10 strobed exactly on the final conversion edge.
    busy_cnt = 0; win_bad = 0;
    strobe_first(8'd0);
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (busy_lz) busy_cnt++;
      if (n >= 10 && n <= 17 && !consistent(an_lz, seg_lz, 0, 0, 0)) win_bad++;
      result_valid = (n == 8);
      result_in    = 8'd10;
    end
    result_valid = 1'b0;
    check("chain busy_cycles", busy_cnt, 16);
    check("chain shows 0", win_bad, 0);
    scan_check("chain_final10", 0, 1, 0);

    // Asynchronous reset in the middle of a conversion.
    strobe_first(8'd200);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst busy", busy_lz, 0);
    check("midrst an", an_lz, 4'b1111);
    check("midrst seg", seg_lz, BLANK);
    check("midrst busy nz", busy_nz, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    busy_cnt = 0;
    repeat (24) begin
      @(negedge clk);
      if (busy_lz) busy_cnt++;
    end
    check("midrst no resume", busy_cnt, 0);
    scan_check("midrst_display", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
